// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front end.
package mips_pkg;

    localparam int unsigned DEFAULT_ADDR_W   = 32;
    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W = mips_pkg::DEFAULT_ADDR_W
) ();

    logic                         imem_req;
    logic [ADDR_W-1:0]            imem_addr;
    logic                         imem_ready;
    logic                         imem_rvalid;
    logic [mips_pkg::INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_slot.sv
// IF/ID pipeline register plus a one-entry hold buffer for a response that
// arrives while decode is stalled; flush kills both.
module if_id_slot #(
    parameter int unsigned ADDR_W = mips_pkg::DEFAULT_ADDR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_i,
    input  logic                         stall_i,
    input  logic                         fill_i,
    input  logic [mips_pkg::INSTR_W-1:0] fill_instr_i,
    input  logic [ADDR_W-1:0]            pc_i,
    output logic                         slot_free_o,
    output logic                         loaded_o,
    output logic                         id_valid_o,
    output logic [mips_pkg::INSTR_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [ADDR_W-1:0]            id_pc4_o
);
    import mips_pkg::*;

    logic               id_valid_q;
    logic [INSTR_W-1:0] id_instr_q;
    logic [ADDR_W-1:0]  id_pc_q;
    logic [ADDR_W-1:0]  id_pc4_q;
    logic               hold_valid_q;
    logic [INSTR_W-1:0] hold_instr_q;
    logic [INSTR_W-1:0] load_instr;

    // The slot only advances when it is empty or decode is taking its contents.
    assign slot_free_o = !id_valid_q || !stall_i;
    assign loaded_o    = !flush_i && slot_free_o && (fill_i || hold_valid_q);
    assign load_instr  = hold_valid_q ? hold_instr_q : fill_instr_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            id_pc4_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else if (flush_i) begin
            id_valid_q   <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (slot_free_o) begin
            id_valid_q   <= loaded_o;
            hold_valid_q <= 1'b0;
            if (loaded_o) begin
                id_instr_q <= load_instr;
                id_pc_q    <= pc_i;
                id_pc4_q   <= pc_i + ADDR_W'(4);
            end
        end else if (fill_i) begin
            hold_valid_q <= 1'b1;
            hold_instr_q <= fill_instr_i;
        end
    end

    assign id_valid_o = id_valid_q;
    assign id_instr_o = id_instr_q;
    assign id_pc_o    = id_pc_q;
    assign id_pc4_o   = id_pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, one outstanding imem request, feeds IF/ID.
// Define IF_PERF_CNT_EN to add the fetch/stall performance counters.
module if_fetch_stage #(
    parameter int unsigned       ADDR_W   = mips_pkg::DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(mips_pkg::DEFAULT_RESET_PC)
) (
    input  logic                         clk,
    input  logic                         reset,
    if_fetch_stage_if.master             imem,
    input  logic                         id_stall_i,
    input  logic                         redirect_valid_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    output logic                         id_valid_o,
    output logic [mips_pkg::INSTR_W-1:0] id_instr_o,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [ADDR_W-1:0]            id_pc4_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_fetch_cnt_o,
    output logic [31:0]                  perf_stall_cnt_o
`endif
);
    import mips_pkg::*;

    fetch_state_e      state_q, state_d;
    logic              discard_q, discard_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              accept;
    logic              fill;
    logic              slot_free;
    logic              slot_loaded;

    assign accept = (state_q == REQ) && imem.imem_ready;
    assign fill   = (state_q == WAIT) && imem.imem_rvalid && !discard_q && !redirect_valid_i;

    if_id_slot #(.ADDR_W(ADDR_W)) u_slot (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (redirect_valid_i),
        .stall_i      (id_stall_i),
        .fill_i       (fill),
        .fill_instr_i (imem.imem_rdata),
        .pc_i         (pc_q),
        .slot_free_o  (slot_free),
        .loaded_o     (slot_loaded),
        .id_valid_o   (id_valid_o),
        .id_instr_o   (id_instr_o),
        .id_pc_o      (id_pc_o),
        .id_pc4_o     (id_pc4_o)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= REQ;
            discard_q <= 1'b0;
            pc_q      <= RESET_PC;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            pc_q      <= pc_d;
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        discard_d = discard_q;
        pc_d      = pc_q;
        if (redirect_valid_i) begin
            pc_d      = redirect_pc_i & ~ADDR_W'(3);
            state_d   = REQ;
            discard_d = 1'b0;
            // A request already in flight (or accepted now) still owes a response to drop.
            if (accept || (state_q == WAIT && !imem.imem_rvalid)) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end
        end else begin
            if (slot_loaded) pc_d = pc_q + ADDR_W'(4);
            unique case (state_q)
                REQ:  if (imem.imem_ready) state_d = WAIT;
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = REQ;
                        end else if (slot_free) begin
                            state_d = REQ;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD:    if (slot_free) state_d = REQ;
                default: state_d = REQ;
            endcase
        end
    end

    // Request is squashed while reset is held so memory never sees a reset-time fetch.
    always_comb begin
        imem.imem_req  = (state_q == REQ) && reset;
        imem.imem_addr = pc_q;
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(slot_loaded);
            stall_cnt_q <= stall_cnt_q + 32'(id_valid_o && id_stall_i);
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed vector tables, corner-case
// sequences and a randomized run against a transaction-level fetch model.
module tb_if_fetch_stage;

    localparam int unsigned AW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_stage_if #(.ADDR_W(AW)) imem ();

    if_fetch_stage #(.ADDR_W(AW), .RESET_PC(32'h0000_3000)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem             (imem),
        .id_stall_i       (id_stall),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .id_valid_o       (id_valid),
        .id_instr_o       (id_instr),
        .id_pc_o          (id_pc),
        .id_pc4_o         (id_pc4)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: outstanding request, drop flag, queue of held responses, slot.
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_held[$];
    bit          m_v;
    logic [31:0] m_instr, m_spc, m_spc4;
    int unsigned m_fetch, m_stallc;

    function automatic void model_reset();
        m_pc = 32'h0000_3000;
        m_out = 1'b0;
        m_drop = 1'b0;
        m_held.delete();
        m_v = 1'b0;
        m_instr = '0;
        m_spc = '0;
        m_spc4 = '0;
        m_fetch = 0;
        m_stallc = 0;
    endfunction

    function automatic bit model_req();
        return !m_out && (m_held.size() == 0);
    endfunction

    function automatic void model_step(input bit ready, input bit rvalid, input logic [31:0] rdata,
                                       input bit stall, input bit redir, input logic [31:0] rpc);
        bit req;
        req = model_req();
        if (m_v && stall) m_stallc++;
        if (redir) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_v = 1'b0;
            m_held.delete();
            if (m_out && rvalid) begin
                m_out = 1'b0;
                m_drop = 1'b0;
            end else if (m_out) begin
                m_drop = 1'b1;
            end else if (req && ready) begin
                m_out = 1'b1;
                m_drop = 1'b1;
            end
        end else begin
            if (req && ready) begin
                m_out = 1'b1;
            end else if (m_out && rvalid) begin
                m_out = 1'b0;
                if (m_drop) m_drop = 1'b0;
                else        m_held.push_back(rdata);
            end
            if (!m_v || !stall) begin
                if (m_held.size() != 0) begin
                    m_instr = m_held.pop_front();
                    m_spc = m_pc;
                    m_spc4 = m_pc + 32'd4;
                    m_pc = m_pc + 32'd4;
                    m_v = 1'b1;
                    m_fetch++;
                end else begin
                    m_v = 1'b0;
                end
            end
        end
    endfunction

    task automatic compare_model();
        check("imem_req", 32'(imem.imem_req), 32'(model_req()));
        check("imem_addr", imem.imem_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(m_v));
        if (m_v) begin
            check("id_instr", id_instr, m_instr);
            check("id_pc", id_pc, m_spc);
            check("id_pc4", id_pc4, m_spc4);
        end
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_fetch));
        check("perf_stall_cnt", perf_stall_cnt, 32'(m_stallc));
`endif
    endtask

    // Called at a negedge: compare, drive this cycle's inputs, advance model and clock.
    task automatic do_cycle(input bit ready, input bit rvalid, input logic [31:0] rdata,
                            input bit stall, input bit redir, input logic [31:0] rpc);
        compare_model();
        imem.imem_ready  = ready;
        imem.imem_rvalid = rvalid;
        imem.imem_rdata  = rdata;
        id_stall         = stall;
        redirect_valid   = redir;
        redirect_pc      = rpc;
        model_step(ready, rvalid, rdata, stall, redir, rpc);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        id_stall         = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem.imem_req), 32'd0);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        model_reset();
        reset = 1'b1;
        #1;
    endtask

    typedef struct {
        bit          rst;
        bit          ready;
        bit          rvalid;
        logic [31:0] rdata;
        bit          stall;
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit ready, input bit rvalid, input logic [31:0] rdata,
                                input bit stall, input bit exp_req, input logic [31:0] exp_addr,
                                input bit exp_valid, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        vec_t v;
        v.rst = rst; v.ready = ready; v.rvalid = rvalid; v.rdata = rdata; v.stall = stall;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_valid = exp_valid;
        v.exp_pc = exp_pc; v.exp_instr = exp_instr;
        return v;
    endfunction

    localparam logic [31:0] I0 = 32'h2408_0001;
    localparam logic [31:0] I1 = 32'h2409_0002;
    localparam logic [31:0] I2 = 32'h012A_5820;
    localparam logic [31:0] I3 = 32'h8C0B_0010;

    vec_t vecs[$];

    bit          mem_busy;
    int unsigned mem_delay;
    logic [31:0] mem_addr;

    initial begin
        clear_inputs();
        model_reset();

        // 1-cycle memory, no stall; then a 5-cycle stall while 3004 returns.
        //            rst rdy rv rdata       st  req addr           v  pc             instr
        vecs.push_back(mk(1, 1, 0, '0,         0, 1, 32'h0000_3000, 0, '0,           '0));
        vecs.push_back(mk(0, 0, 1, I0,         0, 0, 32'h0000_3000, 0, '0,           '0));
        vecs.push_back(mk(0, 1, 0, '0,         0, 1, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 0, 1, I1,         0, 0, 32'h0000_3004, 0, '0,           '0));
        vecs.push_back(mk(0, 1, 0, '0,         0, 1, 32'h0000_3008, 1, 32'h0000_3004, I1));
        vecs.push_back(mk(0, 0, 1, I2,         0, 0, 32'h0000_3008, 0, '0,           '0));
        vecs.push_back(mk(0, 0, 0, '0,         0, 1, 32'h0000_300C, 1, 32'h0000_3008, I2));
        vecs.push_back(mk(1, 1, 0, '0,         0, 1, 32'h0000_3000, 0, '0,           '0));
        vecs.push_back(mk(0, 0, 1, I0,         0, 0, 32'h0000_3000, 0, '0,           '0));
        vecs.push_back(mk(0, 1, 0, '0,         1, 1, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 0, 1, I1,         1, 0, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 0, 0, '0,         1, 0, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 0, 0, '0,         1, 0, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 0, 0, '0,         0, 0, 32'h0000_3004, 1, 32'h0000_3000, I0));
        vecs.push_back(mk(0, 1, 0, '0,         0, 1, 32'h0000_3008, 1, 32'h0000_3004, I1));
        vecs.push_back(mk(0, 0, 1, I2,         0, 0, 32'h0000_3008, 0, '0,           '0));
        vecs.push_back(mk(0, 0, 0, '0,         0, 1, 32'h0000_300C, 1, 32'h0000_3008, I2));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            check($sformatf("vec%0d_req", i), 32'(imem.imem_req), 32'(vecs[i].exp_req));
            check($sformatf("vec%0d_addr", i), imem.imem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), 32'(id_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_pc", i), id_pc, vecs[i].exp_pc);
                check($sformatf("vec%0d_pc4", i), id_pc4, vecs[i].exp_pc + 32'd4);
                check($sformatf("vec%0d_instr", i), id_instr, vecs[i].exp_instr);
            end
            do_cycle(vecs[i].ready, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall, 1'b0, '0);
        end

        // Redirect while waiting: the late response is dropped, refetch from aligned target.
        do_reset();
        do_cycle(1, 0, '0, 0, 0, '0);
        do_cycle(0, 0, '0, 0, 1, 32'h0000_3041);
        do_cycle(0, 1, 32'h0BAD_0BAD, 0, 0, '0);
        check("redir_wait_valid", 32'(id_valid), 32'd0);
        check("redir_wait_req", 32'(imem.imem_req), 32'd1);
        check("redir_wait_addr", imem.imem_addr, 32'h0000_3040);
        do_cycle(1, 0, '0, 0, 0, '0);
        do_cycle(0, 1, I3, 0, 0, '0);
        check("redir_wait_pc", id_pc, 32'h0000_3040);
        check("redir_wait_instr", id_instr, I3);

        // Redirect beats a stalled, valid slot.
        do_reset();
        do_cycle(1, 0, '0, 0, 0, '0);
        do_cycle(0, 1, I0, 0, 0, '0);
        do_cycle(0, 0, '0, 1, 1, 32'h0000_4000);
        check("redir_stall_valid", 32'(id_valid), 32'd0);
        check("redir_stall_addr", imem.imem_addr, 32'h0000_4000);
        check("redir_stall_req", 32'(imem.imem_req), 32'd1);

        // PC wrap at the top of the address space.
        do_cycle(0, 0, '0, 0, 1, 32'hFFFF_FFFE);
        do_cycle(1, 0, '0, 0, 0, '0);
        do_cycle(0, 1, I1, 0, 0, '0);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc4, 32'h0000_0000);
        check("wrap_addr", imem.imem_addr, 32'h0000_0000);

        // Asynchronous reset while a request is outstanding; the stale response is ignored.
        do_reset();
        do_cycle(1, 0, '0, 0, 0, '0);
        do_cycle(0, 1, I0, 0, 0, '0);
        do_cycle(1, 0, '0, 1, 0, '0);
        check("pre_rst_valid", 32'(id_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(id_valid), 32'd0);
        check("async_rst_instr", id_instr, 32'd0);
        check("async_rst_pc", id_pc, 32'd0);
        check("async_rst_pc4", id_pc4, 32'd0);
        check("async_rst_addr", imem.imem_addr, 32'h0000_3000);
        check("async_rst_req", 32'(imem.imem_req), 32'd0);
        @(negedge clk);
        clear_inputs();
        model_reset();
        reset = 1'b1;
        #1;
        do_cycle(0, 1, 32'hDEAD_BEEF, 0, 0, '0);
        check("stale_rvalid_valid", 32'(id_valid), 32'd0);
        check("stale_rvalid_addr", imem.imem_addr, 32'h0000_3000);
        check("stale_rvalid_req", 32'(imem.imem_req), 32'd1);

        // Randomized traffic against the model, with a variable-latency memory.
        do_reset();
        mem_busy = 1'b0;
        mem_delay = 0;
        mem_addr = '0;
        for (int c = 0; c < 4000; c++) begin
            bit          ready, rvalid, stall, redir;
            logic [31:0] rdata, rpc;
            ready = ($urandom_range(0, 3) != 0);
            rvalid = 1'b0;
            rdata = $urandom;
            if (mem_busy) begin
                if (mem_delay == 0) begin
                    rvalid = 1'b1;
                    rdata = ~mem_addr;
                    mem_busy = 1'b0;
                end else begin
                    mem_delay--;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                rvalid = 1'b1;
            end
            stall = ($urandom_range(0, 2) == 0);
            redir = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       rpc = 32'h0000_3000 + 32'($urandom_range(0, 255));
                1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = $urandom;
            endcase
            if (model_req() && ready) begin
                mem_busy = 1'b1;
                mem_delay = $urandom_range(0, 3);
                mem_addr = m_pc;
            end
            do_cycle(ready, rvalid, rdata, stall, redir, rpc);
        end
        compare_model();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
